reg_prim_trio: RTL and testbench

Storage-primitive block that bundles the three basic state elements of the base library: a free-running D register, an enable-gated D register, and a level-sensitive transparent latch. All three share one data input, so a single bench can compare edge-triggered, enable-gated and level-sensitive capture side by side. The block sits in the base layer and is instantiated wherever a pipeline stage, a hold register or a latch is needed.

---
 rtl/reg_prim_pkg.sv | 8 +
 rtl/reg_prim_trio_dff.sv | 29 ++
 rtl/reg_prim_trio.sv | 52 +++++
 tb/tb_reg_prim_trio.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/reg_prim_pkg.sv
// Shared constants and types for the storage-primitive trio.
package reg_prim_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage : reg_prim_pkg

// File: rtl/reg_prim_trio_dff.sv
// Edge-triggered D register with synchronous active-high reset and an optional write enable.
module reg_dff
    import reg_prim_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
    parameter bit                    USE_EN     = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic en_eff;

    // Free-running flavour ignores the enable port entirely.
    assign en_eff = USE_EN ? i_en : 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data <= RST_VAL;
        end else if (en_eff) begin
            o_data <= i_data;
        end
    end

endmodule : reg_dff

// File: rtl/reg_prim_trio.sv
// Free-running register, enable-gated register and transparent latch sharing one data input.
module reg_prim_trio
    import reg_prim_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_ff_data,
    output logic [DATA_WIDTH-1:0] o_ff_en_data,
    output logic [DATA_WIDTH-1:0] o_lch_data
);

    logic [DATA_WIDTH-1:0] lch_q;

    reg_dff #(
        .DATA_WIDTH (DATA_WIDTH),
        .RST_VAL    (RST_VAL),
        .USE_EN     (1'b0)
    ) u_ff (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .i_data (i_data),
        .o_data (o_ff_data)
    );

    reg_dff #(
        .DATA_WIDTH (DATA_WIDTH),
        .RST_VAL    (RST_VAL),
        .USE_EN     (1'b1)
    ) u_ff_en (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .i_data (i_data),
        .o_data (o_ff_en_data)
    );

    // The one intended latch: no clock, no reset, transparent while i_en is high.
    always_latch begin
        if (i_en) begin
            lch_q <= i_data;
        end
    end

    assign o_lch_data = lch_q;

endmodule : reg_prim_trio

// File: tb/tb_reg_prim_trio.sv
// Self-checking bench for reg_prim_trio: directed vector table, corner sequences, random vs model.
module tb_reg_prim_trio;
    import reg_prim_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  en;
    data_t data;
    data_t ff_data;
    data_t ff_en_data;
    data_t lch_data;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Reference state, updated from the behavioural rules only.
    data_t m_ff;
    data_t m_ffen;
    data_t m_lch;
    bit    m_lch_known = 1'b0;

    reg_prim_trio #(
        .DATA_WIDTH (32),
        .RST_VAL    (32'h0000_0000)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_data       (data),
        .o_ff_data    (ff_data),
        .o_ff_en_data (ff_en_data),
        .o_lch_data   (lch_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic  rst;
        logic  en;
        data_t data;
        bit    chk_lch;
        data_t exp_lch;
        data_t exp_ff;
        data_t exp_ffen;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input data_t act, input data_t exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs between edges; the latch model reacts immediately.
    task automatic apply(input logic r, input logic e, input data_t d);
        rst  = r;
        en   = e;
        data = d;
        if (e) begin
            m_lch       = d;
            m_lch_known = 1'b1;
        end
        #1;
    endtask

    // Advance one rising edge; registers sample the stable inputs.
    task automatic tick();
        @(posedge clk);
        m_ff   = rst ? 32'h0 : data;
        m_ffen = rst ? 32'h0 : (en ? data : m_ffen);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        data = 32'hFFFF_0000;

        vecs[0] = '{1'b1, 1'b0, 32'hFFFF_0000, 1'b0, 32'h0,          32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'hFFFF_0000, 1'b0, 32'h0,          32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{1'b0, 1'b0, 32'hFFFF_00FF, 1'b0, 32'h0,          32'hFFFF_00FF, 32'h0000_0000};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_00FF, 1'b0, 32'h0,          32'hFFFF_00FF, 32'h0000_0000};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
        vecs[6] = '{1'b1, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0000};
        vecs[7] = '{1'b0, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5};

        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].data);
            if (vecs[i].chk_lch) check($sformatf("vec%0d_lch_pre_edge", i), lch_data, vecs[i].exp_lch);
            tick();
            check($sformatf("vec%0d_ff", i), ff_data, vecs[i].exp_ff);
            check($sformatf("vec%0d_ff_en", i), ff_en_data, vecs[i].exp_ffen);
            if (vecs[i].chk_lch) check($sformatf("vec%0d_lch_post_edge", i), lch_data, vecs[i].exp_lch);
        end

        // Latch hold: enable falls first, data changes one time unit later.
        apply(1'b0, 1'b1, 32'h1234_5678);
        tick();
        check("hold_setup_ff_en", ff_en_data, 32'h1234_5678);
        apply(1'b0, 1'b0, 32'h1234_5678);
        apply(1'b0, 1'b0, 32'h9ABC_DEF0);
        check("hold_lch_after_data_change", lch_data, 32'h1234_5678);
        tick();
        check("hold_ff", ff_data, 32'h9ABC_DEF0);
        check("hold_ff_en", ff_en_data, 32'h1234_5678);
        check("hold_lch_after_edge", lch_data, 32'h1234_5678);

        // Mid-cycle glitch: enable pulses between edges and is low at the edge.
        apply(1'b0, 1'b1, 32'h1111_1111);
        check("glitch_lch_track1", lch_data, 32'h1111_1111);
        apply(1'b0, 1'b1, 32'h2222_2222);
        check("glitch_lch_track2", lch_data, 32'h2222_2222);
        apply(1'b0, 1'b0, 32'h2222_2222);
        apply(1'b0, 1'b0, 32'h3333_3333);
        check("glitch_lch_hold", lch_data, 32'h2222_2222);
        tick();
        check("glitch_ff", ff_data, 32'h3333_3333);
        check("glitch_ff_en_holds", ff_en_data, 32'h1234_5678);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            apply(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), data_t'($urandom));
            if (m_lch_known) check("rand_lch", lch_data, m_lch);
            if ($urandom_range(0, 2) == 0) begin
                apply(rst, 1'($urandom_range(0, 1)), data_t'($urandom));
                if (m_lch_known) check("rand_lch_glitch", lch_data, m_lch);
                apply(rst, 1'($urandom_range(0, 1)), data_t'($urandom));
                if (m_lch_known) check("rand_lch_glitch2", lch_data, m_lch);
            end
            tick();
            check("rand_ff", ff_data, m_ff);
            check("rand_ff_en", ff_en_data, m_ffen);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_reg_prim_trio
